// File: rtl/br_predict_resolve_pkg.sv
// Shared LC-3b types for branch resolution and prediction.
// NZP condition type, PC-mux select encoding and the NZP match helper.
package lc3b_types;

  typedef logic [2:0] lc3b_nzp;

  typedef enum logic [1:0] {
    PCMUX_NEXT   = 2'd0,
    PCMUX_WB_TGT = 2'd1,
    PCMUX_TRAP   = 2'd2,
    PCMUX_PRED   = 2'd3
  } lc3b_pcmux_sel;

  function automatic logic nzp_match(
    input lc3b_nzp cc,
    input lc3b_nzp ir
  );
    return |(cc & ir);
  endfunction

endpackage

// File: rtl/br_predict_resolve_if.sv
// ID/WB bundle between the pipeline control path and branch resolution.
// Master drives stage info; slave returns prediction and PC-mux controls.
interface br_predict_resolve_if #(
  parameter int PC_W  = 16,
  parameter int CNT_W = 32
);
  import lc3b_types::*;

  logic            id_valid;
  logic            id_op_br;
  logic [PC_W-1:0] id_pc;
  logic            id_pred_taken;

  logic            wb_valid;
  logic            wb_op_br;
  logic            wb_op_jmp;
  logic            wb_op_trap;
  lc3b_nzp         wb_cc;
  lc3b_nzp         wb_ir_nzp;
  logic [PC_W-1:0] wb_pc;
  logic            wb_pred_taken;

  logic [1:0]       pc_mux_sel;
  logic             br_addr_sel;
  logic             mispredict;
  logic [CNT_W-1:0] perf_br_cnt;
  logic [CNT_W-1:0] perf_mis_cnt;

  modport master (
    output id_valid, id_op_br, id_pc,
    output wb_valid, wb_op_br, wb_op_jmp, wb_op_trap,
    output wb_cc, wb_ir_nzp, wb_pc, wb_pred_taken,
    input  id_pred_taken, pc_mux_sel, br_addr_sel,
    input  mispredict, perf_br_cnt, perf_mis_cnt
  );

  modport slave (
    input  id_valid, id_op_br, id_pc,
    input  wb_valid, wb_op_br, wb_op_jmp, wb_op_trap,
    input  wb_cc, wb_ir_nzp, wb_pc, wb_pred_taken,
    output id_pred_taken, pc_mux_sel, br_addr_sel,
    output mispredict, perf_br_cnt, perf_mis_cnt
  );

endinterface

// File: rtl/br_predict_resolve_sat_counter.sv
// Saturating up/down counter with enable; one PHT entry.
// Holds at all-ones when counting up and at zero when counting down.
module sat_counter #(
  parameter int           W       = 2,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic         up,
  output logic [W-1:0] q
);

  logic atMax;
  logic atMin;

  assign atMax = (q == {W{1'b1}});
  assign atMin = (q == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= RST_VAL;
    end else if (en) begin
      if (up && !atMax) begin
        q <= q + 1'b1;
      end else if (!up && !atMin) begin
        q <= q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/br_predict_resolve.sv
// WB branch resolution with a PC-indexed PHT feeding ID predictions.
// Define BR_PERF_CNT_EN to add resolved-branch/mispredict counters.
module br_predict_resolve
  import lc3b_types::*;
#(
  parameter int PC_W     = 16,
  parameter int IDX_BITS = 4,
  parameter int CTR_BITS = 2,
  parameter int CNT_W    = 32
) (
  input logic           clk,
  input logic           reset_n,
  br_predict_resolve_if.slave bus
);

  localparam int NENT = 2 ** IDX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_RST =
    CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

  logic                taken;
  logic                wbBr;
  logic                mis;
  logic                idBr;
  logic                predTaken;
  logic [IDX_BITS-1:0] idIdx;
  logic [IDX_BITS-1:0] wbIdx;
  logic [CTR_BITS-1:0] ctr [NENT];
  lc3b_pcmux_sel       sel;
  logic                addrSel;
  logic                unusedPcBits;

  assign taken = nzp_match(bus.wb_cc, bus.wb_ir_nzp);
  assign wbBr  = bus.wb_valid & bus.wb_op_br;
  assign mis   = wbBr & (taken != bus.wb_pred_taken);
  assign idBr  = bus.id_valid & bus.id_op_br;

  // PCs are word-aligned, so bit 0 carries no index information
  assign idIdx = bus.id_pc[IDX_BITS:1];
  assign wbIdx = bus.wb_pc[IDX_BITS:1];

  assign unusedPcBits = ^{
    bus.id_pc[PC_W-1:IDX_BITS+1], bus.id_pc[0],
    bus.wb_pc[PC_W-1:IDX_BITS+1], bus.wb_pc[0]
  };

  for (genvar g = 0; g < NENT; g++) begin : gPht
    sat_counter #(
      .W      (CTR_BITS),
      .RST_VAL(CTR_RST)
    ) uCtr (
      .clk    (clk),
      .reset_n(reset_n),
      .en     (wbBr && (wbIdx == IDX_BITS'(g))),
      .up     (taken),
      .q      (ctr[g])
    );
  end

  assign predTaken = idBr & ctr[idIdx][CTR_BITS-1];

  always_comb begin
    sel     = PCMUX_NEXT;
    addrSel = 1'b0;
    priority case (1'b1)
      bus.wb_valid & bus.wb_op_jmp:  sel = PCMUX_WB_TGT;
      bus.wb_valid & bus.wb_op_trap: sel = PCMUX_TRAP;
      mis: begin
        sel     = PCMUX_WB_TGT;
        addrSel = ~taken;
      end
      predTaken: sel = PCMUX_PRED;
      default:   sel = PCMUX_NEXT;
    endcase
  end

  assign bus.id_pred_taken = predTaken;
  assign bus.pc_mux_sel    = sel;
  assign bus.br_addr_sel   = addrSel;
  assign bus.mispredict    = mis;

`ifdef BR_PERF_CNT_EN
  logic [CNT_W-1:0] brCnt;
  logic [CNT_W-1:0] misCnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      brCnt  <= '0;
      misCnt <= '0;
    end else begin
      if (wbBr) brCnt <= brCnt + 1'b1;
      if (mis) misCnt <= misCnt + 1'b1;
    end
  end

  assign bus.perf_br_cnt  = brCnt;
  assign bus.perf_mis_cnt = misCnt;
`else
  assign bus.perf_br_cnt  = '0;
  assign bus.perf_mis_cnt = '0;
`endif

endmodule
